db_fe_settings_responder: RTL

- Front-end responder at the daughterboard end of the radio's db_fe settings/readback interface; one instance per radio channel, in the ce_clk domain.
- Decodes timed settings-bus writes into a GPIO/ATR register file.
- Drives daughterboard GPIO from an ATR state machine that follows rx_running/tx_running.
- Answers readback requests with db_fe_rb_stb/data under the address-stable handshake that the radio core uses as readback holdoff.

---
 rtl/db_fe_settings_responder_pkg.sv | 42 ++++
 rtl/db_fe_settings_responder_if.sv | 12 +
 rtl/db_fe_atr_fsm.sv | 82 ++++++++
 rtl/db_fe_settings_responder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/db_fe_settings_responder_pkg.sv
// Shared register map and ATR state encoding for the daughterboard front-end responder.
// Write offsets are relative to SR_BASE and readback offsets are relative to RB_BASE.
package db_fe_settings_responder_pkg;

    localparam logic [2:0] SR_ATR_IDLE    = 3'd0;
    localparam logic [2:0] SR_ATR_RX      = 3'd1;
    localparam logic [2:0] SR_ATR_TX      = 3'd2;
    localparam logic [2:0] SR_ATR_FDX     = 3'd3;
    localparam logic [2:0] SR_DDR         = 3'd4;
    localparam logic [2:0] SR_ATR_DISABLE = 3'd5;
    localparam logic [2:0] SR_CLASSIC_OUT = 3'd6;
    localparam logic [2:0] SR_ATR_DELAY   = 3'd7;

    localparam logic [2:0] RB_GPIO_IN     = 3'd0;
    localparam logic [2:0] RB_STATE_DDR   = 3'd1;
    localparam logic [2:0] RB_CLASSIC_DIS = 3'd2;
    localparam logic [2:0] RB_ATR_RX_IDLE = 3'd3;
    localparam logic [2:0] RB_ATR_FDX_TX  = 3'd4;
    localparam logic [2:0] RB_ATR_DELAY   = 3'd5;

    // State encoding is {tx_act, rx_act}
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RX   = 2'd1,
        ST_TX   = 2'd2,
        ST_FDX  = 2'd3
    } atr_state_t;

    // Widened subtraction so a window near 8'hFF cannot wrap
    function automatic logic in_window(input logic [7:0] addr, input logic [7:0] base);
        logic [8:0] diff;
        diff = {1'b0, addr} - {1'b0, base};
        return diff < 9'd8;
    endfunction

    function automatic logic [2:0] window_offset(input logic [7:0] addr, input logic [7:0] base);
        logic [7:0] diff;
        diff = addr - base;
        return diff[2:0];
    endfunction

endpackage

// File: rtl/db_fe_settings_responder_if.sv
// Settings-write and readback bus between the radio core (master) and the responder (slave).
interface db_fe_settings_responder_if;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [7:0]  rb_addr;
    logic        rb_stb;
    logic [63:0] rb_data;

    modport master (output set_stb, set_addr, set_data, rb_addr, input rb_stb, rb_data);
    modport slave  (input set_stb, set_addr, set_data, rb_addr, output rb_stb, rb_data);
endinterface

// File: rtl/db_fe_atr_fsm.sv
// ATR state register following rx_running/tx_running.
// With DB_FE_ATR_DELAY_EN a rising tx_running is held off by a programmable count.
module db_fe_atr_fsm
    import db_fe_settings_responder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_running,
    input  logic        tx_running,
`ifdef DB_FE_ATR_DELAY_EN
    input  logic [15:0] atr_delay,
`endif
    output atr_state_t  atr_state
);

    atr_state_t state_q, state_d;
    logic       tx_next;

`ifdef DB_FE_ATR_DELAY_EN
    logic        tx_prev;
    logic        counting, counting_d;
    logic [15:0] dly_cnt, dly_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_prev  <= 1'b0;
            counting <= 1'b0;
            dly_cnt  <= 16'd0;
        end else begin
            tx_prev  <= tx_running;
            counting <= counting_d;
            dly_cnt  <= dly_cnt_d;
        end
    end

    // A falling tx_running aborts immediately; a rising edge (re)loads the count
    always_comb begin
        tx_next    = 1'b0;
        counting_d = counting;
        dly_cnt_d  = dly_cnt;
        if (!tx_running) begin
            counting_d = 1'b0;
            dly_cnt_d  = 16'd0;
        end else if (!tx_prev) begin
            if (atr_delay == 16'd0) begin
                tx_next    = 1'b1;
                counting_d = 1'b0;
            end else begin
                counting_d = 1'b1;
                dly_cnt_d  = atr_delay;
            end
        end else if (counting) begin
            dly_cnt_d = dly_cnt - 16'd1;
            if (dly_cnt == 16'd1) begin
                tx_next    = 1'b1;
                counting_d = 1'b0;
            end
        end else begin
            tx_next = state_q[1];
        end
    end
`else
    always_comb begin
        tx_next = tx_running;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = atr_state_t'({tx_next, rx_running});
    end

    assign atr_state = state_q;

endmodule

// File: rtl/db_fe_settings_responder.sv
// Daughterboard front-end responder: settings register file, ATR-driven GPIO and readback.
// Define DB_FE_ATR_DELAY_EN to enable the programmable TX ATR delay (offset 7).
module db_fe_settings_responder
    import db_fe_settings_responder_pkg::*;
#(
    parameter logic [7:0]  SR_BASE    = 8'd160,
    parameter logic [7:0]  RB_BASE    = 8'd16,
    parameter int unsigned RB_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    db_fe_settings_responder_if.slave    bus,
    input  logic                         rx_running,
    input  logic                         tx_running,
    input  logic [31:0]                  gpio_in,
    output logic [31:0]                  gpio_out,
    output logic [31:0]                  gpio_ddr,
    output logic [1:0]                   atr_state
);

    logic [31:0] atr_idle, atr_rx, atr_tx, atr_fdx, ddr, atr_disable, classic_out;
    logic [15:0] atr_delay;
    logic        wr_en;
    logic [2:0]  wr_off;

    assign wr_en  = bus.set_stb && in_window(bus.set_addr, SR_BASE);
    assign wr_off = window_offset(bus.set_addr, SR_BASE);

    always_ff @(posedge clk) begin
        if (reset) begin
            atr_idle    <= 32'd0;
            atr_rx      <= 32'd0;
            atr_tx      <= 32'd0;
            atr_fdx     <= 32'd0;
            ddr         <= 32'd0;
            atr_disable <= 32'd0;
            classic_out <= 32'd0;
        end else if (wr_en) begin
            case (wr_off)
                SR_ATR_IDLE:    atr_idle    <= bus.set_data;
                SR_ATR_RX:      atr_rx      <= bus.set_data;
                SR_ATR_TX:      atr_tx      <= bus.set_data;
                SR_ATR_FDX:     atr_fdx     <= bus.set_data;
                SR_DDR:         ddr         <= bus.set_data;
                SR_ATR_DISABLE: atr_disable <= bus.set_data;
                SR_CLASSIC_OUT: classic_out <= bus.set_data;
                default: ;
            endcase
        end
    end

`ifdef DB_FE_ATR_DELAY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            atr_delay <= 16'd0;
        end else if (wr_en && wr_off == SR_ATR_DELAY) begin
            atr_delay <= bus.set_data[15:0];
        end
    end
`else
    assign atr_delay = 16'd0;
`endif

    atr_state_t atr_cur;

    db_fe_atr_fsm u_atr_fsm (
        .clk        (clk),
        .reset      (reset),
        .rx_running (rx_running),
        .tx_running (tx_running),
`ifdef DB_FE_ATR_DELAY_EN
        .atr_delay  (atr_delay),
`endif
        .atr_state  (atr_cur)
    );

    assign atr_state = atr_cur;
    assign gpio_ddr  = ddr;

    logic [31:0] atr_sel;
    always_comb begin
        atr_sel = atr_idle;
        case (atr_cur)
            ST_RX:   atr_sel = atr_rx;
            ST_TX:   atr_sel = atr_tx;
            ST_FDX:  atr_sel = atr_fdx;
            default: atr_sel = atr_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out <= 32'd0;
        end else begin
            gpio_out <= (atr_disable & classic_out) | (~atr_disable & atr_sel);
        end
    end

    // Pins are asynchronous to ce_clk
    logic [31:0] gpio_meta, gpio_sync;
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_meta <= 32'd0;
            gpio_sync <= 32'd0;
        end else begin
            gpio_meta <= gpio_in;
            gpio_sync <= gpio_meta;
        end
    end

    logic [63:0] rb_next;
    always_comb begin
        rb_next = 64'd0;
        if (in_window(bus.rb_addr, RB_BASE)) begin
            case (window_offset(bus.rb_addr, RB_BASE))
                RB_GPIO_IN:     rb_next = {32'd0, gpio_sync};
                RB_STATE_DDR:   rb_next = {30'd0, atr_cur, ddr};
                RB_CLASSIC_DIS: rb_next = {classic_out, atr_disable};
                RB_ATR_RX_IDLE: rb_next = {atr_rx, atr_idle};
                RB_ATR_FDX_TX:  rb_next = {atr_fdx, atr_tx};
                RB_ATR_DELAY:   rb_next = {48'd0, atr_delay};
                default:        rb_next = 64'd0;
            endcase
        end
    end

    // rb_stb asserts once rb_addr has been stable for RB_LATENCY cycles and holds until it moves
    logic [7:0] last_addr;
    logic [3:0] rb_cnt;
    logic       rb_stb_q;
    logic [63:0] rb_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_addr <= 8'd0;
            rb_cnt    <= 4'd0;
            rb_stb_q  <= 1'b0;
            rb_data_q <= 64'd0;
        end else begin
            last_addr <= bus.rb_addr;
            rb_data_q <= rb_next;
            if (bus.rb_addr != last_addr) begin
                rb_cnt   <= 4'd0;
                rb_stb_q <= 1'b0;
            end else begin
                rb_cnt   <= (rb_cnt == 4'(RB_LATENCY)) ? rb_cnt : rb_cnt + 4'd1;
                rb_stb_q <= (rb_cnt == 4'(RB_LATENCY - 1)) | rb_stb_q;
            end
        end
    end

    assign bus.rb_stb  = rb_stb_q;
    assign bus.rb_data = rb_data_q;

endmodule
